// File: rtl/tmr_pkg.sv
// tmr_pkg: shared definitions for the TMR vote controller slice.
//   state_t     - controller FSM states
//   FID_*       - fault_id encoding (0 none, 1..3 replica number)
//   ERRCNT_MAX  - saturation value of err_count
//   CNT_W       - width of the per-replica consecutive-outvote counters
package tmr_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EVAL   = 2'd1,
        RESYNC = 2'd2,
        FATAL  = 2'd3
    } state_t;

    localparam logic [1:0] FID_NONE = 2'd0;
    localparam logic [1:0] FID_R1   = 2'd1;
    localparam logic [1:0] FID_R2   = 2'd2;
    localparam logic [1:0] FID_R3   = 2'd3;

    localparam logic [7:0] ERRCNT_MAX = 8'd255;

    localparam int CNT_W = 4;

endpackage

// File: rtl/tmr_lane_voter.sv
// tmr_lane_voter: combinational 2-of-3 majority voter.
//   a, b, c   in  WIDTH  replica values 1, 2, 3
//   voted     out WIDTH  majority value (0 when all three differ)
//   disagree  out 1      all three replicas differ
//   fault_id  out 2      replica outvoted by the other two (FID_NONE if none)
module tmr_lane_voter
    import tmr_pkg::*;
#(
    parameter int WIDTH = 2
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] voted,
    output logic             disagree,
    output logic [1:0]       fault_id
);

    always_comb begin
        // NOTE: every output gets a default first so no path through the
        // if-chain leaves one unassigned (which would infer a latch).
        voted    = '0;
        disagree = 1'b0;
        fault_id = FID_NONE;
        if (a == b && b == c) begin
            voted = a;
        end else if (a == b) begin
            voted    = a;
            fault_id = FID_R3;
        end else if (a == c) begin
            voted    = a;
            fault_id = FID_R2;
        end else if (b == c) begin
            voted    = b;
            fault_id = FID_R1;
        end else begin
            disagree = 1'b1;
        end
    end

endmodule

// File: rtl/tmr_vote_controller.sv
// tmr_vote_controller: sequencing and fault management around a TMR voter.
// Accepts one replica triple per valid/ready handshake, votes on it for one
// cycle, registers the result, tracks consecutive outvotes per replica and
// requests a resync of a replica that is outvoted FAULT_LIMIT times in a row.
//
// Ports:
//   clk, rst       clock (rising edge), asynchronous active-high reset
//   sample_valid   in   triple on in1/in2/in3 is valid
//   sample_ready   out  controller can accept a triple (IDLE only)
//   in1..in3       in   replica values
//   out            out  registered voted value, held between pulses
//   out_valid      out  one-cycle pulse: out/error/fault_id are fresh
//   error          out  one-cycle pulse with out_valid on triple disagreement
//   fault_id       out  replica outvoted in the last sample (0 none)
//   resync_req     out  resync request, high while in RESYNC
//   resync_id      out  replica being resynced (1..3)
//   resync_data    out  voted value to load into that replica
//   resync_ack     in   resync completed (only looked at in RESYNC)
//   err_count      out  saturating count of samples with any disagreement
//   fatal          out  sticky unrecoverable flag
//
// Build option: define TMR_STICKY_FATAL_EN to lock the controller in FATAL
// on a triple disagreement; without it fatal is tied to 0.
module tmr_vote_controller
    import tmr_pkg::*;
#(
    parameter int WIDTH       = 2,
    parameter int FAULT_LIMIT = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sample_valid,
    output logic             sample_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic             error,
    output logic [1:0]       fault_id,
    output logic             resync_req,
    output logic [1:0]       resync_id,
    output logic [WIDTH-1:0] resync_data,
    input  logic             resync_ack,
    output logic [7:0]       err_count,
    output logic             fatal
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(FAULT_LIMIT);

    state_t             state, state_next;
    logic [WIDTH-1:0]   cap1, cap2, cap3;
    logic [CNT_W-1:0]   cnt      [3];
    logic [CNT_W-1:0]   cnt_next [3];
    logic               hit;

    logic [WIDTH-1:0]   v_out;
    logic               v_err;
    logic [1:0]         v_fid;

    tmr_lane_voter #(.WIDTH(WIDTH)) u_voter (
        .a        (cap1),
        .b        (cap2),
        .c        (cap3),
        .voted    (v_out),
        .disagree (v_err),
        .fault_id (v_fid)
    );

    assign sample_ready = (state == IDLE);
    assign resync_req   = (state == RESYNC);
`ifdef TMR_STICKY_FATAL_EN
    assign fatal        = (state == FATAL);
`else
    assign fatal        = 1'b0;
`endif

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        hit        = 1'b0;
        case (state)
            IDLE: begin
                if (sample_valid) state_next = EVAL;
            end
            EVAL: begin
                // A triple disagreement leaves all counters untouched; otherwise
                // the odd replica counts up and every agreeing replica clears.
                if (!v_err) begin
                    for (int i = 0; i < 3; i++) begin
                        if (v_fid == 2'(i + 1)) begin
                            cnt_next[i] = (cnt[i] >= LIMIT) ? LIMIT : cnt[i] + 1'b1;
                            if (cnt_next[i] == LIMIT) hit = 1'b1;
                        end else begin
                            cnt_next[i] = '0;
                        end
                    end
                end
                if (hit) begin
                    state_next = RESYNC;
                end else if (v_err) begin
`ifdef TMR_STICKY_FATAL_EN
                    state_next = FATAL;
`else
                    state_next = IDLE;
`endif
                end else begin
                    state_next = IDLE;
                end
            end
            RESYNC: begin
                if (resync_ack) begin
                    for (int i = 0; i < 3; i++) begin
                        if (resync_id == 2'(i + 1)) cnt_next[i] = '0;
                    end
                    state_next = IDLE;
                end
            end
            FATAL: begin
                state_next = FATAL;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the counter array is only three small registers, so it is
            // reset together with the rest of the state rather than left
            // uninitialised like a RAM would be.
            state       <= IDLE;
            cnt         <= '{default: '0};
            cap1        <= '0;
            cap2        <= '0;
            cap3        <= '0;
            out         <= '0;
            out_valid   <= 1'b0;
            error       <= 1'b0;
            fault_id    <= FID_NONE;
            resync_id   <= FID_NONE;
            resync_data <= '0;
            err_count   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state     <= state_next;
            cnt       <= cnt_next;
            out_valid <= (state == EVAL);
            error     <= (state == EVAL) && v_err;
            if (state == IDLE && sample_valid) begin
                cap1 <= in1;
                cap2 <= in2;
                cap3 <= in3;
            end
            if (state == EVAL) begin
                out      <= v_out;
                fault_id <= v_fid;
                if ((v_fid != FID_NONE || v_err) && err_count != ERRCNT_MAX)
                    err_count <= err_count + 8'd1;
                if (hit) begin
                    resync_id   <= v_fid;
                    resync_data <= v_out;
                end
            end
        end
    end

endmodule

// File: tb/tb_tmr_vote_controller.sv
// tb_tmr_vote_controller: directed, table-driven bench for tmr_vote_controller
// (WIDTH = 2, FAULT_LIMIT = 3). Inputs are driven and outputs sampled on the
// falling clock edge. Define TMR_STICKY_FATAL_EN for both RTL and bench to
// exercise the sticky-fatal build.
module tb_tmr_vote_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       sample_valid;
    logic       sample_ready;
    logic [1:0] in1, in2, in3;
    logic [1:0] out;
    logic       out_valid;
    logic       error;
    logic [1:0] fault_id;
    logic       resync_req;
    logic [1:0] resync_id;
    logic [1:0] resync_data;
    logic       resync_ack;
    logic [7:0] err_count;
    logic       fatal;

    int n_cmp = 0;
    int n_bad = 0;

    tmr_vote_controller #(.WIDTH(2), .FAULT_LIMIT(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .in1          (in1),
        .in2          (in2),
        .in3          (in3),
        .out          (out),
        .out_valid    (out_valid),
        .error        (error),
        .fault_id     (fault_id),
        .resync_req   (resync_req),
        .resync_id    (resync_id),
        .resync_data  (resync_data),
        .resync_ack   (resync_ack),
        .err_count    (err_count),
        .fatal        (fatal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] a, b, c;
        logic [1:0] eo;
        logic       ee;
        logic [1:0] ef;
    } vec_t;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Waits (bounded) at falling edges until sample_ready is high.
    task automatic wait_ready(input string nm);
        int k = 0;
        while (sample_ready !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (sample_ready !== 1'b1) check({nm, "_ready_timeout"}, 32'(sample_ready), 32'd1);
    endtask

    // One handshake, then check the out_valid pulse lands exactly one cycle
    // after EVAL with the expected vote. Ends on a falling edge.
    task automatic do_sample(input string nm, input logic [1:0] a, b, c,
                             input logic [1:0] eo, input logic ee, input logic [1:0] ef);
        wait_ready(nm);
        in1 = a; in2 = b; in3 = c;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        check({nm, "_ov_eval"}, 32'(out_valid), 32'd0);
        @(negedge clk);
        check({nm, "_ov"},  32'(out_valid), 32'd1);
        check({nm, "_out"}, 32'(out),       32'(eo));
        check({nm, "_err"}, 32'(error),     32'(ee));
        check({nm, "_fid"}, 32'(fault_id),  32'(ef));
        @(negedge clk);
        check({nm, "_ov_drop"}, 32'(out_valid), 32'd0);
    endtask

    // Handshake without checks, used for bulk counting.
    task automatic raw_sample(input logic [1:0] a, b, c);
        wait_ready("raw");
        in1 = a; in2 = b; in3 = c;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    vec_t vecs [8];

    initial begin
        vecs[0] = '{2'b10, 2'b10, 2'b10, 2'b10, 1'b0, 2'd0};
        vecs[1] = '{2'b01, 2'b11, 2'b11, 2'b11, 1'b0, 2'd1};
        vecs[2] = '{2'b00, 2'b00, 2'b11, 2'b00, 1'b0, 2'd3};
        vecs[3] = '{2'b11, 2'b01, 2'b11, 2'b11, 1'b0, 2'd2};
        vecs[4] = '{2'b01, 2'b01, 2'b01, 2'b01, 1'b0, 2'd0};
        vecs[5] = '{2'b10, 2'b11, 2'b11, 2'b11, 1'b0, 2'd1};
        vecs[6] = '{2'b00, 2'b10, 2'b10, 2'b10, 1'b0, 2'd1};
        vecs[7] = '{2'b11, 2'b11, 2'b11, 2'b11, 1'b0, 2'd0};

        rst = 1'b1; sample_valid = 1'b0; resync_ack = 1'b0;
        in1 = '0; in2 = '0; in3 = '0;
        do_reset();

        // Reset state.
        check("rst_ready",  32'(sample_ready), 32'd1);
        check("rst_ov",     32'(out_valid),    32'd0);
        check("rst_out",    32'(out),          32'd0);
        check("rst_err",    32'(error),        32'd0);
        check("rst_fid",    32'(fault_id),     32'd0);
        check("rst_req",    32'(resync_req),   32'd0);
        check("rst_rid",    32'(resync_id),    32'd0);
        check("rst_rdata",  32'(resync_data),  32'd0);
        check("rst_errcnt", 32'(err_count),    32'd0);
        check("rst_fatal",  32'(fatal),        32'd0);

        // resync_ack outside RESYNC has no effect.
        resync_ack = 1'b1;
        @(negedge clk);
        resync_ack = 1'b0;
        check("ack_idle_ready", 32'(sample_ready), 32'd1);
        check("ack_idle_req",   32'(resync_req),   32'd0);

        // Table: no replica reaches three consecutive outvotes.
        for (int i = 0; i < 8; i++)
            do_sample($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].c,
                      vecs[i].eo, vecs[i].ee, vecs[i].ef);
        check("tbl_errcnt", 32'(err_count),  32'd5);
        check("tbl_noreq",  32'(resync_req), 32'd0);

        // Replica 1 outvoted three times -> resync held until ack.
        do_reset();
        for (int i = 0; i < 3; i++)
            do_sample($sformatf("r1f%0d", i), 2'b01, 2'b11, 2'b11, 2'b11, 1'b0, 2'd1);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("rs_req%0d", i),   32'(resync_req),   32'd1);
            check($sformatf("rs_id%0d", i),    32'(resync_id),    32'd1);
            check($sformatf("rs_data%0d", i),  32'(resync_data),  32'(2'b11));
            check($sformatf("rs_ready%0d", i), 32'(sample_ready), 32'd0);
            @(negedge clk);
        end
        resync_ack = 1'b1;
        @(negedge clk);
        resync_ack = 1'b0;
        check("rs_ack_req",   32'(resync_req),   32'd0);
        check("rs_ack_ready", 32'(sample_ready), 32'd1);
        check("rs_errcnt",    32'(err_count),    32'd3);
        // Counter was cleared by the ack: two more outvotes must not resync.
        do_sample("r1g0", 2'b00, 2'b11, 2'b11, 2'b11, 1'b0, 2'd1);
        do_sample("r1g1", 2'b00, 2'b11, 2'b11, 2'b11, 1'b0, 2'd1);
        check("rs_cleared_req", 32'(resync_req), 32'd0);

        // Replica 2: two outvotes, unanimous, two outvotes -> no resync.
        do_reset();
        do_sample("r2a0", 2'b11, 2'b00, 2'b11, 2'b11, 1'b0, 2'd2);
        do_sample("r2a1", 2'b11, 2'b00, 2'b11, 2'b11, 1'b0, 2'd2);
        do_sample("r2u",  2'b01, 2'b01, 2'b01, 2'b01, 1'b0, 2'd0);
        do_sample("r2b0", 2'b11, 2'b00, 2'b11, 2'b11, 1'b0, 2'd2);
        do_sample("r2b1", 2'b11, 2'b00, 2'b11, 2'b11, 1'b0, 2'd2);
        check("r2_req",    32'(resync_req), 32'd0);
        check("r2_errcnt", 32'(err_count),  32'd4);

        // Triple disagreement.
        do_sample("tri", 2'b00, 2'b01, 2'b10, 2'b00, 1'b1, 2'd0);
        check("tri_errcnt", 32'(err_count), 32'd5);
`ifdef TMR_STICKY_FATAL_EN
        repeat (4) begin
            check("tri_fatal",       32'(fatal),        32'd1);
            check("tri_ready_stuck", 32'(sample_ready), 32'd0);
            @(negedge clk);
        end
        do_reset();
        check("tri_fatal_clr", 32'(fatal),        32'd0);
        check("tri_ready_clr", 32'(sample_ready), 32'd1);
`else
        check("tri_fatal", 32'(fatal),        32'd0);
        check("tri_ready", 32'(sample_ready), 32'd1);
`endif

        // Asynchronous reset in the middle of RESYNC.
        do_reset();
        for (int i = 0; i < 3; i++)
            do_sample($sformatf("r3f%0d", i), 2'b11, 2'b11, 2'b00, 2'b11, 1'b0, 2'd3);
        check("mid_req_before", 32'(resync_req), 32'd1);
        check("mid_id_before",  32'(resync_id),  32'd3);
        #2 rst = 1'b1;
        #1;
        check("mid_req_async",   32'(resync_req),   32'd0);
        check("mid_ready_async", 32'(sample_ready), 32'd1);
        check("mid_ov_async",    32'(out_valid),    32'd0);
        check("mid_rid_async",   32'(resync_id),    32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_sample("r3g0", 2'b11, 2'b11, 2'b00, 2'b11, 1'b0, 2'd3);
        do_sample("r3g1", 2'b11, 2'b11, 2'b00, 2'b11, 1'b0, 2'd3);
        check("mid_cnt_cleared", 32'(resync_req), 32'd0);

        // err_count saturation: alternate outvoted replicas so no resync fires.
        do_reset();
        for (int i = 0; i < 260; i++) begin
            if (i % 2 == 0) raw_sample(2'b01, 2'b10, 2'b10);
            else            raw_sample(2'b10, 2'b01, 2'b10);
        end
        check("errcnt_sat", 32'(err_count),  32'd255);
        check("sat_noreq",  32'(resync_req), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
